dmi_jtag_dr_ctrl: RTL and testbench
===================================

// Module: dmi_jtag_dr_ctrl
// PURPOSE
//  TCK-domain DMI access register and request sequencer, directly downstream of the JTAG TAP.
//  - Consumes the TAP's DR strobes while IR=DMIACCESS and shifts the DMI DR.
//  - Turns UpdateDr into one valid/ready DMI request; collects the response.
//  - Returns dmi_tdo and sticky dmistat to the TAP.
//  - Request/response ports feed the TCK<->system-clock CDC in front of the debug module.
// PARAMETERS
//  AddrWidth  7  DMI address bits; must equal abits reported in dtmcs. DR length = AddrWidth+34
// PORTS
//  tck_i               in   1   JTAG clock; all state on posedge
//  trst_ni             in   1   reset, asynchronous, active-low
//  test_logic_reset_i  in   1   TAP in Test-Logic-Reset (synchronous clear)
//  dmi_access_i        in   1   IR selects DMIACCESS
//  capture_dr_i        in   1   TAP CaptureDr
//  shift_dr_i          in   1   TAP ShiftDr
//  update_dr_i         in   1   TAP UpdateDr
//  dmi_reset_i         in   1   dtmcs.dmireset; clears sticky error
//  dmi_tdi_i           in   1   serial data in
//  dmi_tdo_o           out  1   serial data out = dr_q[0] (combinational)
//  dmi_error_o         out  2   sticky dmistat: 0 ok, 2 op failed, 3 busy
//  dmi_req_valid_o     out  1   request valid
//  dmi_req_ready_i     in   1   CDC accepts request
//  dmi_req_addr_o      out  AW  request address
//  dmi_req_op_o        out  2   1 read, 2 write
//  dmi_req_data_o      out  32  write data
//  dmi_resp_valid_i    in   1   response valid
//  dmi_resp_ready_o    out  1   ready for response
//  dmi_resp_data_i     in   32  read data
//  dmi_resp_resp_i     in   2   0 success, else failed
// BEHAVIOUR
//  Reset (trst_ni low, async): FSM=Idle; dr_q, addr_q, data_q, error_q = 0.
//    Outputs at reset: all valids/readies 0, dmi_error_o=0, dmi_tdo_o=0.
//  DR layout, LSB first on wire: [1:0] op, [33:2] data, [AW+33:34] addr.
//  Strobes act only when dmi_access_i=1:
//  - Capture: dr_q <= {addr_q, data_q, error_q}; error_q = result of the last access.
//    If FSM != Idle: error_q <= 3 and captured op = 3.
//  - Shift: dr_q <= {dmi_tdi_i, dr_q[AW+33:1]}.
//  - Update, error_q != 0: op ignored, no request.
//  - Update, FSM != Idle: error_q <= 3, no new request.
//  - Update, op=0 (nop) or op=3: no request.
//  - Update, op=1 or 2: addr_q, data_q <= DR fields; FSM <= Read or Write.
//  FSM states: Idle, Read, WaitRead, Write, WaitWrite.
//  - Read/Write: req_valid=1, fields from addr_q/data_q/op.
//    Valid is asserted the cycle after UpdateDr and held with stable fields until req_ready.
//    req_ready=1 -> WaitRead/WaitWrite next cycle.
//  - Wait*: resp_ready=1; on resp_valid -> Idle.
//    WaitRead: data_q <= resp_data. WaitWrite: data_q unchanged.
//    resp_resp != 0 -> error_q <= 2.
//  - resp_ready=0 outside Wait*. Responses outside Wait* are ignored (protocol error, SVA).
//  Sticky error: only dmi_reset_i, test_logic_reset_i or trst_ni clear error_q.
//    Busy (3) wins over failed (2) when both occur in the same cycle.
//    dmi_reset_i in the same cycle as a new error: the error wins.
//  test_logic_reset_i: clears dr_q and error_q.
//    Does NOT abort Read/Write/Wait*: an issued request still completes its handshake, so the CDC never sees valid dropped.
//  dmi_access_i=0: strobes ignored; FSM still runs to completion.
//  No pipelining: at most one outstanding request.
// TESTING
//  1. Shift DR addr=0x10, data=0, op=1, UpdateDr; req_ready=1; resp 0xDEADBEEF/0.
//     -> req_valid 1 cycle after update; next capture+shift out gives data=0xDEADBEEF, op=0.
//  2. Write addr=0x04, data=0x12345678; hold req_ready=0 for 5 cycles.
//     -> valid and fields stable 5 cycles; accepted on cycle 6.
//  3. New UpdateDr op=1 while WaitRead.
//     -> no second request; dmi_error_o=3; later ops ignored until dmi_reset_i.
//     -> after dmi_reset_i, error 0 and the next op is issued.
//  4. Response with resp=2.
//     -> dmi_error_o=2, captured op=2; stays 2 across further updates until dmi_reset_i.
//  5. test_logic_reset_i asserted while Read with req_ready=0.
//     -> valid held until ready; error_q=0; dr_q=0.
//  6. trst_ni low mid-WaitWrite.
//     -> immediate Idle, all outputs 0; first transfer after release is normal.

Source files
------------

// File: rtl/dmi_jtag_dr_ctrl_if.sv
// DMI request/response bundle between the JTAG DTM and the TCK<->system CDC.
// master: DTM side (drives requests, accepts responses); slave: CDC side.
interface dmi_jtag_dr_ctrl_if #(
    parameter int unsigned AddrWidth = 7
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic [1:0]           req_op;
    logic [31:0]          req_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_data;
    logic [1:0]           resp_resp;

    modport master (
        output req_valid, req_addr, req_op, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_resp
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_resp
    );
endinterface

// File: rtl/dmi_jtag_dr_ctrl.sv
// TCK-domain DMI access register: shifts the DMI DR, issues one request per
// UpdateDr and collects its response; returns dmi_tdo and sticky dmistat.
// Ports: tck_i/trst_ni clock and async reset; TAP strobes (test_logic_reset_i,
// dmi_access_i, capture/shift/update_dr_i, dmi_reset_i, dmi_tdi_i);
// dmi_tdo_o serial out; dmi_error_o sticky status; dmi request/response bundle.
module dmi_jtag_dr_ctrl #(
    parameter int unsigned AddrWidth = 7
) (
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       test_logic_reset_i,
    input  logic       dmi_access_i,
    input  logic       capture_dr_i,
    input  logic       shift_dr_i,
    input  logic       update_dr_i,
    input  logic       dmi_reset_i,
    input  logic       dmi_tdi_i,
    output logic       dmi_tdo_o,
    output logic [1:0] dmi_error_o,
    dmi_jtag_dr_ctrl_if.master dmi
);
    localparam int unsigned DrWidth = AddrWidth + 34;

    typedef enum logic [2:0] {
        Idle, Read, WaitRead, Write, WaitWrite
    } state_e;

    state_e state_q, state_d;

    logic [DrWidth-1:0]   dr_q;
    logic [AddrWidth-1:0] addr_q;
    logic [31:0]          data_q;
    logic [1:0]           error_q, error_d;

    logic [1:0]           dr_op;
    logic [31:0]          dr_data;
    logic [AddrWidth-1:0] dr_addr;

    logic idle, capture, shift, update;
    logic busy, issue, resp_fire, resp_fail;

    assign dr_op   = dr_q[1:0];
    assign dr_data = dr_q[33:2];
    assign dr_addr = dr_q[DrWidth-1:34];

    assign idle    = (state_q == Idle);
    assign capture = dmi_access_i & capture_dr_i;
    assign shift   = dmi_access_i & shift_dr_i;
    assign update  = dmi_access_i & update_dr_i;

    // Any DR access while a transfer is in flight reports busy.
    assign busy  = (capture | update) & ~idle;
    assign issue = update & idle & (error_q == 2'd0)
                 & ((dr_op == 2'd1) | (dr_op == 2'd2));

    assign resp_fail = resp_fire & (dmi.resp_resp != 2'd0);

    assign dmi_tdo_o     = dr_q[0];
    assign dmi_error_o   = error_q;
    assign dmi.req_addr  = addr_q;
    assign dmi.req_data  = data_q;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dmi.req_valid  = 1'b0;
        dmi.req_op     = 2'd0;
        dmi.resp_ready = 1'b0;
        resp_fire      = 1'b0;
        unique case (state_q)
            Idle: begin
                if (issue) begin
                    state_d = dr_op[1] ? Write : Read;
                end
            end
            Read: begin
                dmi.req_valid = 1'b1;
                dmi.req_op    = 2'd1;
                if (dmi.req_ready) begin
                    state_d = WaitRead;
                end
            end
            Write: begin
                dmi.req_valid = 1'b1;
                dmi.req_op    = 2'd2;
                if (dmi.req_ready) begin
                    state_d = WaitWrite;
                end
            end
            WaitRead, WaitWrite: begin
                dmi.resp_ready = 1'b1;
                if (dmi.resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Later assignments win: a new error beats dmireset, busy beats failed.
    // Test-Logic-Reset is a full clear.
    always_comb begin
        error_d = error_q;
        if (dmi_reset_i) error_d = 2'd0;
        if (resp_fail)   error_d = 2'd2;
        if (busy)        error_d = 2'd3;
        if (test_logic_reset_i) error_d = 2'd0;
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 2'd0;
        end else begin
            error_q <= error_d;
            if (test_logic_reset_i) begin
                dr_q <= '0;
            end else if (capture) begin
                dr_q <= {addr_q, data_q, (idle ? error_q : 2'd3)};
            end else if (shift) begin
                dr_q <= {dmi_tdi_i, dr_q[DrWidth-1:1]};
            end
            if (issue) begin
                addr_q <= dr_addr;
                data_q <= dr_data;
            end
            if (resp_fire && (state_q == WaitRead)) begin
                data_q <= dmi.resp_data;
            end
        end
    end

    resp_only_in_wait_a: assert property (
        @(posedge tck_i) disable iff (!trst_ni)
        dmi.resp_valid |-> dmi.resp_ready
    );

    req_stable_a: assert property (
        @(posedge tck_i) disable iff (!trst_ni)
        (dmi.req_valid && !dmi.req_ready) |=>
        (dmi.req_valid &&
         $stable({dmi.req_addr, dmi.req_op, dmi.req_data}))
    );
endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// Directed bench for dmi_jtag_dr_ctrl: DR scans, request/response
// handshakes, sticky error handling and both reset paths.
module tb_dmi_jtag_dr_ctrl;
    localparam int unsigned AW = 7;

    logic       tck = 1'b0;
    logic       trst_n = 1'b0;
    logic       tlr = 1'b0;
    logic       acc = 1'b1;
    logic       cap = 1'b0;
    logic       sh = 1'b0;
    logic       upd = 1'b0;
    logic       dmi_rst = 1'b0;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [1:0] err;

    int n_chk = 0;
    int n_fail = 0;

    dmi_jtag_dr_ctrl_if #(.AddrWidth(AW)) dmi ();

    dmi_jtag_dr_ctrl #(.AddrWidth(AW)) dut (
        .tck_i              (tck),
        .trst_ni            (trst_n),
        .test_logic_reset_i (tlr),
        .dmi_access_i       (acc),
        .capture_dr_i       (cap),
        .shift_dr_i         (sh),
        .update_dr_i        (upd),
        .dmi_reset_i        (dmi_rst),
        .dmi_tdi_i          (tdi),
        .dmi_tdo_o          (tdo),
        .dmi_error_o        (err),
        .dmi                (dmi)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge tck);
    endtask

    function automatic logic [40:0] dr(input logic [6:0] a,
                                       input logic [31:0] d,
                                       input logic [1:0] op);
        return {a, d, op};
    endfunction

    // Capture, shift 41 bits (LSB first), then UpdateDr.
    task automatic scan(input logic [40:0] din, output logic [40:0] dout);
        cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int i = 0; i < 41; i++) begin
            sh = 1'b1;
            tdi = din[i];
            dout[i] = tdo;
            tick();
        end
        sh = 1'b0;
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] rdata, input logic [1:0] rresp);
        int n;
        n = 0;
        while (!dmi.req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", 64'(dmi.req_valid), 64'(1));
        dmi.req_ready = 1'b1;
        tick();
        dmi.req_ready = 1'b0;
        chk("resp_rdy", 64'(dmi.resp_ready), 64'(1));
        dmi.resp_valid = 1'b1;
        dmi.resp_data = rdata;
        dmi.resp_resp = rresp;
        tick();
        dmi.resp_valid = 1'b0;
        dmi.resp_data = '0;
        dmi.resp_resp = '0;
    endtask

    task automatic pulse_dmi_reset();
        dmi_rst = 1'b1;
        tick();
        dmi_rst = 1'b0;
    endtask

    logic [40:0] dout;

    initial begin
        dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b0;
        dmi.resp_data = '0;
        dmi.resp_resp = '0;

        #1;
        chk("rst_out", 64'({dmi.req_valid, dmi.resp_ready, err, tdo}),
            64'(0));
        tick();
        trst_n = 1'b1;
        tick();

        // 1: read 0x10
        scan(dr(7'h10, 32'h0, 2'd1), dout);
        chk("t1_cap0", 64'(dout), 64'(0));
        chk("t1_req", 64'({dmi.req_valid, dmi.req_addr, dmi.req_op}),
            64'({1'b1, 7'h10, 2'd1}));
        xfer(32'hDEADBEEF, 2'd0);

        // 2: write 0x04 with back-pressure
        scan(dr(7'h04, 32'h12345678, 2'd2), dout);
        chk("t1_rdata", 64'(dout), 64'(dr(7'h10, 32'hDEADBEEF, 2'd0)));
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold", 64'({dmi.req_valid, dmi.req_addr, dmi.req_op,
                                dmi.req_data}),
                64'({1'b1, 7'h04, 2'd2, 32'h12345678}));
            tick();
        end
        dmi.req_ready = 1'b1;
        chk("t2_acc", 64'({dmi.req_valid, dmi.req_addr, dmi.req_op,
                           dmi.req_data}),
            64'({1'b1, 7'h04, 2'd2, 32'h12345678}));
        tick();
        dmi.req_ready = 1'b0;
        chk("t2_wait", 64'({dmi.req_valid, dmi.resp_ready}), 64'(2'b01));
        dmi.resp_valid = 1'b1;
        dmi.resp_data = 32'hFFFFFFFF;
        tick();
        dmi.resp_valid = 1'b0;
        dmi.resp_data = '0;

        // 3: busy while WaitRead
        scan(dr(7'h20, 32'h0, 2'd1), dout);
        chk("t2_keep", 64'(dout), 64'(dr(7'h04, 32'h12345678, 2'd0)));
        dmi.req_ready = 1'b1;
        tick();
        dmi.req_ready = 1'b0;
        scan(dr(7'h21, 32'h0, 2'd1), dout);
        chk("t3_capbusy", 64'(dout), 64'(dr(7'h20, 32'h0, 2'd3)));
        chk("t3_noreq", 64'({dmi.req_valid, dmi.resp_ready, err}),
            64'({1'b0, 1'b1, 2'd3}));
        dmi.resp_valid = 1'b1;
        dmi.resp_data = 32'hCAFEF00D;
        tick();
        dmi.resp_valid = 1'b0;
        dmi.resp_data = '0;
        scan(dr(7'h11, 32'h0, 2'd1), dout);
        chk("t3_sticky", 64'(dout), 64'(dr(7'h20, 32'hCAFEF00D, 2'd3)));
        tick();
        chk("t3_ignored", 64'({dmi.req_valid, err}), 64'({1'b0, 2'd3}));
        pulse_dmi_reset();
        chk("t3_clr", 64'(err), 64'(0));
        scan(dr(7'h11, 32'h0, 2'd1), dout);
        chk("t3_reissue", 64'({dmi.req_valid, dmi.req_addr}),
            64'({1'b1, 7'h11}));
        xfer(32'h0BADF00D, 2'd0);

        // 4: failed response
        scan(dr(7'h05, 32'h0, 2'd1), dout);
        chk("t3_rdata", 64'(dout), 64'(dr(7'h11, 32'h0BADF00D, 2'd0)));
        xfer(32'h55AA55AA, 2'd2);
        chk("t4_err", 64'(err), 64'(2));
        scan(dr(7'h06, 32'h99, 2'd2), dout);
        chk("t4_cap", 64'(dout), 64'(dr(7'h05, 32'h55AA55AA, 2'd2)));
        chk("t4_noreq", 64'({dmi.req_valid, err}), 64'({1'b0, 2'd2}));
        scan(dr(7'h07, 32'h0, 2'd1), dout);
        chk("t4_sticky", 64'({dmi.req_valid, err}), 64'({1'b0, 2'd2}));
        pulse_dmi_reset();
        chk("t4_clr", 64'(err), 64'(0));

        // 5: Test-Logic-Reset during Read
        scan(dr(7'h33, 32'h0, 2'd1), dout);
        chk("t5_req", 64'(dmi.req_valid), 64'(1));
        cap = 1'b1;
        tick();
        cap = 1'b0;
        chk("t5_busy", 64'({err, tdo}), 64'({2'd3, 1'b1}));
        tlr = 1'b1;
        tick();
        tlr = 1'b0;
        chk("t5_tlr", 64'({err, tdo}), 64'(0));
        tick();
        tick();
        chk("t5_held", 64'({dmi.req_valid, dmi.req_addr, dmi.req_op}),
            64'({1'b1, 7'h33, 2'd1}));
        xfer(32'h77777777, 2'd0);
        scan(dr(7'h00, 32'h0, 2'd0), dout);
        chk("t5_done", 64'(dout), 64'(dr(7'h33, 32'h77777777, 2'd0)));

        // 6: trst_ni during WaitWrite
        scan(dr(7'h7F, 32'hA5A5A5A5, 2'd2), dout);
        dmi.req_ready = 1'b1;
        tick();
        dmi.req_ready = 1'b0;
        chk("t6_wait", 64'(dmi.resp_ready), 64'(1));
        trst_n = 1'b0;
        #1;
        chk("t6_rst", 64'({dmi.req_valid, dmi.resp_ready, err, tdo}),
            64'(0));
        tick();
        trst_n = 1'b1;
        tick();
        scan(dr(7'h01, 32'h0, 2'd1), dout);
        chk("t6_cap0", 64'(dout), 64'(0));
        chk("t6_req", 64'({dmi.req_valid, dmi.req_addr, dmi.req_op}),
            64'({1'b1, 7'h01, 2'd1}));
        xfer(32'h11112222, 2'd0);
        scan(dr(7'h00, 32'h0, 2'd0), dout);
        chk("t6_rdata", 64'(dout), 64'(dr(7'h01, 32'h11112222, 2'd0)));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
